seq_shift_add_mul: RTL and testbench

//   Multi-cycle radix-2 shift-add multiplier in the execute stage, upstream of the N-bit ripple adder.

---
 rtl/seq_shift_add_mul_pkg.sv | 10 +
 rtl/seq_shift_add_mul_if.sv | 29 ++
 rtl/seq_shift_add_mul_adder.sv | 23 ++
 rtl/seq_shift_add_mul.sv | 135 +++++++++++++
 tb/tb_seq_shift_add_mul.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_shift_add_mul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_NEG, S_DONE} mul_state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/seq_shift_add_mul_if.sv
// Start/operand/result bundle of the shift-add multiplier.
// is_signed exists only when SEQ_MUL_SIGNED_EN is defined.
interface seq_mul_if #(
  parameter int N = 32
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
`ifdef SEQ_MUL_SIGNED_EN
  logic         is_signed;
`endif
  logic         busy;
  logic         done;
  logic [N-1:0] product_hi;
  logic [N-1:0] product_lo;
  logic         zero;

`ifdef SEQ_MUL_SIGNED_EN
  modport master (output start, a, b, is_signed,
                  input  busy, done, product_hi, product_lo, zero);
  modport slave  (input  start, a, b, is_signed,
                  output busy, done, product_hi, product_lo, zero);
`else
  modport master (output start, a, b,
                  input  busy, done, product_hi, product_lo, zero);
  modport slave  (input  start, a, b,
                  output busy, done, product_hi, product_lo, zero);
`endif
endinterface

// File: rtl/seq_shift_add_mul_adder.sv
// Codebase N-bit ripple-carry adder (nBitsADD).
module nBitsADD #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] out,
  output logic         cout,
  output logic         overflow
);
  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign out[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout     = c[N];
  assign overflow = c[N] ^ c[N-1];
endmodule

// File: rtl/seq_shift_add_mul.sv
// Radix-2 shift-add multiplier: one partial product per cycle, 2N-bit result.
// Define SEQ_MUL_SIGNED_EN to add is_signed (magnitude multiply + final negate).
module seq_shift_add_mul
  import seq_mul_pkg::*;
#(
  parameter int N = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_mul_if.slave bus
);
  // state  | meaning
  // S_IDLE | waiting for start
  // S_RUN  | one shift-add iteration per cycle, N cycles
  // S_NEG  | negate the 2N-bit product (signed build only)
  // S_DONE | product valid, done pulse; a new start is accepted here
  localparam int            CW       = cnt_w(N);
  localparam int            PW       = 2 * N;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  mul_state_t    state;
  logic [N-1:0]  m, q, acc_hi;
  logic [CW-1:0] cnt;
  logic [N-1:0]  pp, sum, nxt_hi, nxt_lo;
  logic [N-1:0]  ld_m, ld_q;
  logic          cout;
  logic          busy_r, done_r, zero_r;
  logic [N-1:0]  prod_hi_r, prod_lo_r;

  assign pp = q[0] ? m : '0;

  nBitsADD #(.N(N)) u_add (
    .a        (acc_hi),
    .b        (pp),
    .cin      (1'b0),
    .out      (sum),
    .cout     (cout),
    .overflow ()
  );

  // Carry-out becomes the new accumulator MSB; the sum LSB drops into Q.
  assign nxt_hi = {cout, sum[N-1:1]};
  assign nxt_lo = {sum[0], q[N-1:1]};

`ifdef SEQ_MUL_SIGNED_EN
  logic          neg_pend;
  logic          ld_neg;
  logic [PW-1:0] neg_val;

  // Negating the most-negative value yields 2^(N-1), which is still a valid magnitude.
  assign ld_m    = (bus.is_signed && bus.a[N-1]) ? (~bus.a + N'(1)) : bus.a;
  assign ld_q    = (bus.is_signed && bus.b[N-1]) ? (~bus.b + N'(1)) : bus.b;
  assign ld_neg  = bus.is_signed & (bus.a[N-1] ^ bus.b[N-1]);
  assign neg_val = ~{acc_hi, q} + PW'(1);
`else
  assign ld_m = bus.a;
  assign ld_q = bus.b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      m         <= '0;
      q         <= '0;
      acc_hi    <= '0;
      cnt       <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      zero_r    <= 1'b0;
      prod_hi_r <= '0;
      prod_lo_r <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      neg_pend  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            m      <= ld_m;
            q      <= ld_q;
            acc_hi <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= S_RUN;
`ifdef SEQ_MUL_SIGNED_EN
            neg_pend <= ld_neg;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_hi <= nxt_hi;
          q      <= nxt_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
`ifdef SEQ_MUL_SIGNED_EN
            if (neg_pend) begin
              state <= S_NEG;
            end else begin
`else
            begin
`endif
              state     <= S_DONE;
              busy_r    <= 1'b0;
              done_r    <= 1'b1;
              prod_hi_r <= nxt_hi;
              prod_lo_r <= nxt_lo;
              zero_r    <= ~|{nxt_hi, nxt_lo};
            end
          end
        end
`ifdef SEQ_MUL_SIGNED_EN
        S_NEG: begin
          {acc_hi, q} <= neg_val;
          state       <= S_DONE;
          busy_r      <= 1'b0;
          done_r      <= 1'b1;
          prod_hi_r   <= neg_val[PW-1:N];
          prod_lo_r   <= neg_val[N-1:0];
          zero_r      <= ~|neg_val;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.zero       = zero_r;
  assign bus.product_hi = prod_hi_r;
  assign bus.product_lo = prod_lo_r;
endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Self-checking bench for seq_shift_add_mul: vector table, scoreboard, corner sequences.
// Signed cases run only when SEQ_MUL_SIGNED_EN is defined.
module tb_seq_shift_add_mul;
  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   t_acc   = 0;
  int   done_cnt = 0;

  typedef struct {
    logic [2*N-1:0] prod;
    logic           zero;
  } exp_t;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] prod;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];

  seq_mul_if #(.N(N)) mif ();

  seq_shift_add_mul #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mif.done) begin
        done_cnt++;
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 with product %h, expected no done",
                   {mif.product_hi, mif.product_lo});
        end else begin
          e = sb_q.pop_front();
          chk("product", {mif.product_hi, mif.product_lo}, e.prod);
          chk("zero", 64'(mif.zero), 64'(e.zero));
          chk("busy_in_done", 64'(mif.busy), 64'd0);
        end
      end
    end
  end

  // Drive one start pulse at posedge+1; returns just after the accepting edge.
  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv, input logic [2*N-1:0] ep);
    exp_t e;
    mif.a     = av;
    mif.b     = bv;
    mif.start = 1'b1;
    e.prod    = ep;
    e.zero    = (ep == '0);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    t_acc     = cyc;
    mif.start = 1'b0;
    chk("busy_after_start", 64'(mif.busy), 64'd1);
  endtask

  task automatic wait_done(input int lat, input string nm);
    while (!mif.done && (cyc - t_acc) < 300) begin
      @(posedge clk);
      #1;
    end
    chk({nm, "_latency"}, 64'(cyc - t_acc), 64'(lat));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int done_before;

    vecs[0] = '{32'd3,         32'd5,         64'd15};
    vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001};
    vecs[2] = '{32'd0,         32'h12345678,  64'd0};
    vecs[3] = '{32'd2,         32'd2,         64'd4};
    vecs[4] = '{32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF};
    vecs[5] = '{32'd1,         32'hFFFFFFFF,  64'h00000000_FFFFFFFF};
    vecs[6] = '{32'h80000000,  32'h80000000,  64'h40000000_00000000};
    vecs[7] = '{32'h12345678,  32'h10,        64'h00000001_23456780};

    rst_n     = 1'b0;
    mif.start = 1'b0;
    mif.a     = '0;
    mif.b     = '0;
`ifdef SEQ_MUL_SIGNED_EN
    mif.is_signed = 1'b0;
`endif
    #12;
    chk("rst_busy", 64'(mif.busy), 64'd0);
    chk("rst_done", 64'(mif.done), 64'd0);
    chk("rst_product", {mif.product_hi, mif.product_lo}, 64'd0);
    chk("rst_zero", 64'(mif.zero), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].prod);
      wait_done(N, "vec");
      @(posedge clk);
      #1;
      chk("done_one_cycle", 64'(mif.done), 64'd0);
      chk("product_held", {mif.product_hi, mif.product_lo}, vecs[i].prod);
    end

    // start while busy is ignored; start in the DONE cycle is accepted
    issue(32'd7, 32'd6, 64'd42);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    mif.a     = 32'd9;
    mif.b     = 32'd9;
    mif.start = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    mif.start = 1'b0;
    chk("busy_ignores_start", 64'(mif.busy), 64'd1);
    chk("product_stable_midop", {mif.product_hi, mif.product_lo}, vecs[7].prod);
    wait_done(N, "ignored_start");
    issue(32'd4, 32'd4, 64'd16);
    wait_done(N, "back_to_back");
    @(posedge clk);
    #1;
    chk("b2b_idle_done", 64'(mif.done), 64'd0);

    // asynchronous reset mid-operation aborts without a done
    issue(32'd5, 32'd5, 64'd25);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(mif.busy), 64'd0);
    chk("abort_product", {mif.product_hi, mif.product_lo}, 64'd0);
    chk("abort_zero", 64'(mif.zero), 64'd0);
    void'(sb_q.pop_back());
    done_before = done_cnt;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2 * N) begin
      @(posedge clk);
      #1;
    end
    chk("no_done_after_abort", 64'(done_cnt - done_before), 64'd0);
    issue(32'd11, 32'd13, 64'd143);
    wait_done(N, "after_abort");
    @(posedge clk);
    #1;

`ifdef SEQ_MUL_SIGNED_EN
    mif.is_signed = 1'b1;
    issue(32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB);
    wait_done(N + 1, "signed_neg");
    @(posedge clk);
    #1;
    issue(32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    wait_done(N, "signed_minint");
    @(posedge clk);
    #1;
    issue(32'hFFFFFFFD, 32'hFFFFFFF9, 64'd21);
    wait_done(N, "signed_both_neg");
    @(posedge clk);
    #1;
    mif.is_signed = 1'b0;
    issue(32'hFFFFFFFD, 32'd7, 64'h00000006_FFFFFFEB);
    wait_done(N, "unsigned_big_a");
    @(posedge clk);
    #1;
`endif

    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
